instruction_store: RTL and testbench
====================================

INSTRUCTION_STORE -- requirements
Module: instruction_store

Interface
REQ-001 SHALL have parameter WORDS, default 256, meaning number of 32-bit program words (instruction_pointer range 0..WORDS-1).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port load_start  input  1  single-cycle pulse that begins a program load.
REQ-005 SHALL have port load_valid  input  1  load_data holds a valid program byte.
REQ-006 SHALL have port load_data  input  8  program byte, most-significant byte of each word first.
REQ-007 SHALL have port load_ready  output  1  store accepts a byte this cycle.
REQ-008 SHALL have port load_end  input  1  single-cycle pulse that ends the load.
REQ-009 SHALL have port instruction_pointer  input  8  fetch address from the CPU.
REQ-010 SHALL have port instruction  output  32  fetched instruction word to the CPU.
REQ-011 SHALL have port cpu_enable  output  1  high only when the CPU may execute.
REQ-012 SHALL have port program_length  output  9  number of complete words written in the last load.
REQ-013 SHALL have port load_error  output  1  sticky flag for a partial word or overflow.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RUN; reset enters IDLE.
REQ-015 IDLE: load_start -> LOAD; otherwise remain. cpu_enable=0, load_ready=0.
REQ-016 LOAD entry SHALL clear write address, byte counter (0..3), program_length and load_error.
REQ-017 In LOAD, load_ready SHALL be 1 every cycle; a byte is accepted when load_valid&load_ready.
REQ-018 Accepted bytes SHALL shift into a 32-bit assembly register; the 4th byte of a word SHALL write {b0,b1,b2,b3} to memory[write address] on the same edge, increment write address and program_length, and reset the byte counter.
REQ-019 Write address SHALL wrap from WORDS-1 to 0; a write at wrap SHALL set load_error, and program_length SHALL saturate at WORDS.
REQ-020 load_end in LOAD -> RUN; if the byte counter is non-zero, the partial word SHALL be discarded and load_error set.
REQ-021 A byte accepted in the same cycle as load_end SHALL be counted before the end is evaluated.
REQ-022 load_start in LOAD SHALL restart the load (REQ-016); load_start in RUN -> LOAD.
REQ-023 RUN: cpu_enable=1, load_ready=0; load_valid ignored.
REQ-024 instruction SHALL be registered: instruction at edge n+1 equals memory[instruction_pointer sampled at edge n] (one-cycle latency).
REQ-025 If instruction_pointer >= program_length, instruction SHALL be 32'h0000_0000 one cycle later.
REQ-026 In IDLE and LOAD, instruction SHALL be 32'h0000_0000.
REQ-027 cpu_enable SHALL rise one cycle after entry to RUN, so the first fetch result is valid when the CPU first sees enable.
REQ-028 Memory contents SHALL persist across reset; only program_length gates visibility.

Reset
REQ-029 On reset: state=IDLE, instruction=0, cpu_enable=0, load_ready=0, program_length=0, load_error=0, write address=0, byte counter=0.
REQ-030 reset SHALL take priority over every other input, including mid-load; a partial load is abandoned with no further writes.

Verification
REQ-031 Reset, load_start, bytes 11 22 33 44 55 66 77 88, load_end, ip=1 -> program_length=2, load_error=0, cpu_enable=1, instruction=32'h55667788 one cycle after ip applied.
REQ-032 Load 6 bytes then load_end -> program_length=1, load_error=1; ip=1 -> instruction=0.
REQ-033 Load with load_valid toggling every other cycle, 4 bytes DE AD BE EF -> word 0 = 32'hDEADBEEF, no lost or duplicated byte.
REQ-034 Load WORDS+1 words (word k = k) -> load_error=1, program_length=WORDS, memory[0] = WORDS.
REQ-035 Assert reset after 2 of 4 bytes, then full load of AABBCCDD -> word 0 = 32'hAABBCCDD, load_error=0.
REQ-036 In RUN, step ip 0,1,0 on consecutive edges -> instruction follows with exactly one-cycle lag; load_start mid-RUN -> cpu_enable=0 on next edge.

Source files
------------

// File: rtl/instruction_store.sv
// Program memory that is filled byte-wise over a valid/ready load port and then
// serves 32-bit instruction words to a CPU with one cycle of fetch latency.
module instruction_store #(
    parameter int WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    input  logic        load_end,
    input  logic [7:0]  instruction_pointer,
    output logic [31:0] instruction,
    output logic        cpu_enable,
    output logic [8:0]  program_length,
    output logic        load_error
);

    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [8:0] LEN_MAX = 9'(WORDS);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] write_addr;
    logic [1:0]    byte_count;
    logic [23:0]   assembly;
    logic [31:0]   mem [WORDS];

    logic          accept;
    logic          word_done;
    logic          partial_at_end;
    logic          fetch_enable;

    // Load handshake: a byte transfers on any rising edge where load_valid and
    // load_ready are both high; load_ready is high exactly while in LOAD.
    assign accept         = (state == LOAD) && load_valid && load_ready && !load_start;
    assign word_done      = accept && (byte_count == 2'd3);
    assign partial_at_end = accept ? (byte_count != 2'd3) : (byte_count != 2'd0);
    assign fetch_enable   = (state == RUN) && (state_nxt == RUN);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_start) state_nxt = LOAD;
            LOAD:    if (load_start) state_nxt = LOAD;
                     else if (load_end) state_nxt = RUN;
            RUN:     if (load_start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            load_ready     <= 1'b0;
            cpu_enable     <= 1'b0;
            instruction    <= 32'h0000_0000;
            write_addr     <= '0;
            byte_count     <= 2'd0;
            assembly       <= 24'h0;
            program_length <= 9'd0;
            load_error     <= 1'b0;
        end else begin
            state      <= state_nxt;
            load_ready <= (state_nxt == LOAD);
            // Fetch is gated on staying in RUN so enable and the first valid
            // word appear together, and both drop on the edge that leaves RUN.
            cpu_enable <= fetch_enable;
            if (fetch_enable && ({1'b0, instruction_pointer} < program_length))
                instruction <= mem[instruction_pointer[AW-1:0]];
            else
                instruction <= 32'h0000_0000;

            if (load_start) begin
                write_addr     <= '0;
                byte_count     <= 2'd0;
                assembly       <= 24'h0;
                program_length <= 9'd0;
                load_error     <= 1'b0;
            end else if (state == LOAD) begin
                if (accept) begin
                    assembly   <= {assembly[15:0], load_data};
                    byte_count <= byte_count + 2'd1;
                end
                if (word_done) begin
                    write_addr <= (write_addr == AW'(WORDS - 1)) ? '0 : write_addr + AW'(1);
                    // A write once the store is already full overwrites from word 0.
                    if (program_length == LEN_MAX)
                        load_error <= 1'b1;
                    else
                        program_length <= program_length + 9'd1;
                end
                if (load_end) begin
                    byte_count <= 2'd0;
                    if (partial_at_end)
                        load_error <= 1'b1;
                end
            end
        end
    end

    // No reset on the array: contents survive reset, program_length gates them.
    always_ff @(posedge clk) begin
        if (word_done && !reset)
            mem[write_addr] <= {assembly, load_data};
    end

endmodule

// File: tb/tb_instruction_store.sv
// Directed bench for instruction_store: load sequences, fetch vector table,
// and multi-cycle corner cases (partial words, overflow, reset mid-load).
module tb_instruction_store;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_ready;
    logic        load_end;
    logic [7:0]  instruction_pointer;
    logic [31:0] instruction;
    logic        cpu_enable;
    logic [8:0]  program_length;
    logic        load_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  ip;
        logic [31:0] exp;
    } fetch_vec_t;

    fetch_vec_t vecs [6];
    logic [7:0] tog_bytes [4];

    instruction_store #(.WORDS(256)) dut (
        .clk                 (clk),
        .reset               (reset),
        .load_start          (load_start),
        .load_valid          (load_valid),
        .load_data           (load_data),
        .load_ready          (load_ready),
        .load_end            (load_end),
        .instruction_pointer (instruction_pointer),
        .instruction         (instruction),
        .cpu_enable          (cpu_enable),
        .program_length      (program_length),
        .load_error          (load_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_data  = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic end_load();
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        tick();
    endtask

    task automatic fetch_check(input string name, input logic [7:0] ip, input logic [31:0] exp);
        instruction_pointer = ip;
        tick();
        check(name, instruction, exp);
    endtask

    initial begin
        vecs[0] = '{ip: 8'd0,   exp: 32'h1122_3344};
        vecs[1] = '{ip: 8'd1,   exp: 32'h5566_7788};
        vecs[2] = '{ip: 8'd0,   exp: 32'h1122_3344};
        vecs[3] = '{ip: 8'd2,   exp: 32'h0000_0000};
        vecs[4] = '{ip: 8'd255, exp: 32'h0000_0000};
        vecs[5] = '{ip: 8'd1,   exp: 32'h5566_7788};
        tog_bytes[0] = 8'hDE; tog_bytes[1] = 8'hAD;
        tog_bytes[2] = 8'hBE; tog_bytes[3] = 8'hEF;

        reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00;
        load_end = 1'b0; instruction_pointer = 8'd0;
        tick(); tick();
        reset = 1'b0;
        check("rst_cpu_enable", cpu_enable, 0);
        check("rst_load_ready", load_ready, 0);
        check("rst_length", program_length, 0);
        check("rst_error", load_error, 0);
        check("rst_instruction", instruction, 0);

        // Two-word program, then fetch table with one-cycle lag.
        start_load();
        check("load_ready_in_load", load_ready, 1);
        check("cpu_enable_in_load", cpu_enable, 0);
        put_byte(8'h11); put_byte(8'h22); put_byte(8'h33); put_byte(8'h44);
        put_byte(8'h55); put_byte(8'h66); put_byte(8'h77); put_byte(8'h88);
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        check("enable_low_on_run_entry", cpu_enable, 0);
        check("ready_low_in_run", load_ready, 0);
        check("len_two_words", program_length, 2);
        check("err_clean_load", load_error, 0);
        fetch_check("first_fetch_ip1", 8'd1, 32'h5566_7788);
        check("enable_high_in_run", cpu_enable, 1);
        for (int i = 0; i < 6; i++)
            fetch_check($sformatf("fetch_vec%0d", i), vecs[i].ip, vecs[i].exp);

        // load_start mid-RUN drops enable on the next edge.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("restart_enable_low", cpu_enable, 0);
        check("restart_ready_high", load_ready, 1);
        check("restart_len_cleared", program_length, 0);
        check("restart_instr_zero", instruction, 0);

        // Six bytes: one word plus a discarded partial.
        for (int i = 1; i <= 6; i++) put_byte(8'(i));
        end_load();
        check("partial_len", program_length, 1);
        check("partial_error", load_error, 1);
        fetch_check("partial_ip1_zero", 8'd1, 32'h0);
        fetch_check("partial_ip0", 8'd0, 32'h0102_0304);

        // load_valid toggling every other cycle.
        start_load();
        check("restart_clears_error", load_error, 0);
        for (int i = 0; i < 8; i++) begin
            load_valid = (i % 2 == 0);
            load_data  = load_valid ? tog_bytes[i / 2] : 8'hFF;
            tick();
        end
        load_valid = 1'b0;
        end_load();
        check("toggle_len", program_length, 1);
        check("toggle_error", load_error, 0);
        fetch_check("toggle_word", 8'd0, 32'hDEAD_BEEF);

        // Last byte accepted together with load_end completes the word.
        start_load();
        put_byte(8'h12); put_byte(8'h34); put_byte(8'h56);
        load_valid = 1'b1; load_data = 8'h78; load_end = 1'b1;
        tick();
        load_valid = 1'b0; load_end = 1'b0;
        tick();
        check("end_with_byte_len", program_length, 1);
        check("end_with_byte_err", load_error, 0);
        fetch_check("end_with_byte_word", 8'd0, 32'h1234_5678);

        // Byte with load_end leaving three bytes is a partial word.
        start_load();
        put_byte(8'hA1); put_byte(8'hA2);
        load_valid = 1'b1; load_data = 8'hA3; load_end = 1'b1;
        tick();
        load_valid = 1'b0; load_end = 1'b0;
        tick();
        check("end_partial3_len", program_length, 0);
        check("end_partial3_err", load_error, 1);

        // Reset mid-load, then a clean load.
        start_load();
        put_byte(8'hAA); put_byte(8'hBB);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_ready", load_ready, 0);
        check("midrst_error", load_error, 0);
        check("midrst_len", program_length, 0);
        check("midrst_enable", cpu_enable, 0);
        start_load();
        put_byte(8'hAA); put_byte(8'hBB); put_byte(8'hCC); put_byte(8'hDD);
        end_load();
        check("after_rst_err", load_error, 0);
        check("after_rst_len", program_length, 1);
        fetch_check("after_rst_word", 8'd0, 32'hAABB_CCDD);

        // Overflow: WORDS+1 words, word k = k.
        start_load();
        for (int k = 0; k < 256; k++) begin
            for (int b = 0; b < 4; b++) put_byte(8'((32'(k)) >> (24 - 8 * b)));
        end
        check("full_len", program_length, 256);
        check("full_no_error", load_error, 0);
        for (int b = 0; b < 4; b++) put_byte(8'((32'd256) >> (24 - 8 * b)));
        end_load();
        check("ovf_len_saturates", program_length, 256);
        check("ovf_error", load_error, 1);
        fetch_check("ovf_word0", 8'd0, 32'h0000_0100);
        fetch_check("ovf_word1", 8'd1, 32'h0000_0001);
        fetch_check("ovf_word255", 8'd255, 32'h0000_00FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
